// File: rtl/gray_counter_n.sv
// -----------------------------------------------------------------------------
// gray_counter_n
//
// Registered N-bit up/down counter that presents its state both as a binary
// count and as the matching Gray code. It can be loaded in parallel from a
// Gray-coded value and pulses tc for one cycle on each terminal event. It is
// intended as the pointer/counter primitive for multi-bit clock-domain-crossing
// and encoder blocks.
//
// Parameters:
//   N         counter width in bits (N >= 2)
//   SATURATE  0 = wrap modulo 2^N, 1 = hold at the terminal value
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (bin = gray = tc = 0)
//   en         count enable, one step per clk while high
//   up         direction: 1 = increment, 0 = decrement
//   load       synchronous parallel load, overrides en
//   load_gray  load value, Gray-coded
//   bin        registered binary count
//   gray       registered Gray code of bin
//   tc         one-cycle terminal-count pulse
//
// Per-edge priority: rst > load > en > hold. All outputs are registered, so
// there is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module gray_counter_n #(
    parameter int N        = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [N-1:0] load_gray,
    output logic [N-1:0] bin,
    output logic [N-1:0] gray,
    output logic         tc
);

    localparam logic [N-1:0] BIN_MAX = {N{1'b1}};

    logic [N-1:0] bin_nxt;
    logic [N-1:0] gray_nxt;
    logic         tc_nxt;
    logic         at_term;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at and
    // above it, computed as a running XOR from the MSB down.
    function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Terminal value depends on the direction of the step being requested.
    assign at_term = up ? (bin == BIN_MAX) : (bin == '0);

    always_comb begin
        bin_nxt = bin;
        tc_nxt  = 1'b0;

        if (load) begin
            bin_nxt = gray2bin(load_gray);
        end else if (en) begin
            if (at_term) begin
                tc_nxt = 1'b1;
                if (!SATURATE) begin
                    bin_nxt = up ? '0 : BIN_MAX;
                end
            end else begin
                bin_nxt = up ? (bin + 1'b1) : (bin - 1'b1);
            end
        end

        // On load the Gray register takes the supplied code directly; it is
        // by construction the encoding of the decoded binary value.
        gray_nxt = load ? load_gray : (bin_nxt ^ (bin_nxt >> 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin  <= '0;
            gray <= '0;
            tc   <= 1'b0;
        end else begin
            bin  <= bin_nxt;
            gray <= gray_nxt;
            tc   <= tc_nxt;
        end
    end

endmodule

// File: tb/tb_gray_counter_n.sv
// -----------------------------------------------------------------------------
// tb_gray_counter_n
//
// Three instances: 0 = N4 wrapping, 1 = N4 saturating, 2 = N6 wrapping.
// Each driven cycle updates an independent reference model and pushes the
// expected outputs to a scoreboard queue; the entry is popped and compared
// one time unit after the following rising edge.
// -----------------------------------------------------------------------------
module tb_gray_counter_n;

    typedef struct {
        int d;
        int b;
        int g;
        int t;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en_v   [3];
    logic       up_v   [3];
    logic       load_v [3];
    logic [5:0] lg_v   [3];

    logic [3:0] bin0, gray0, bin1, gray1;
    logic [5:0] bin2, gray2;
    logic       tc0, tc1, tc2;

    int   n_tests;
    int   n_fail;
    int   mb  [3];
    int   mtc [3];
    exp_t sb  [$];

    gray_counter_n #(.N(4), .SATURATE(1'b0)) u_w4 (
        .clk(clk), .rst(rst), .en(en_v[0]), .up(up_v[0]), .load(load_v[0]),
        .load_gray(lg_v[0][3:0]), .bin(bin0), .gray(gray0), .tc(tc0)
    );

    gray_counter_n #(.N(4), .SATURATE(1'b1)) u_s4 (
        .clk(clk), .rst(rst), .en(en_v[1]), .up(up_v[1]), .load(load_v[1]),
        .load_gray(lg_v[1][3:0]), .bin(bin1), .gray(gray1), .tc(tc1)
    );

    gray_counter_n #(.N(6), .SATURATE(1'b0)) u_w6 (
        .clk(clk), .rst(rst), .en(en_v[2]), .up(up_v[2]), .load(load_v[2]),
        .load_gray(lg_v[2]), .bin(bin2), .gray(gray2), .tc(tc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void get_act(input int d, output int b, output int g, output int t);
        case (d)
            0:       begin b = int'(bin0); g = int'(gray0); t = int'(tc0); end
            1:       begin b = int'(bin1); g = int'(gray1); t = int'(tc1); end
            default: begin b = int'(bin2); g = int'(gray2); t = int'(tc2); end
        endcase
    endfunction

    // Reference decode written as XOR of all right shifts of the code.
    function automatic int ref_g2b(input int g, input int n);
        int b;
        b = 0;
        for (int s = 0; s < n; s++) b = b ^ (g >> s);
        return b & ((1 << n) - 1);
    endfunction

    function automatic void ref_step(input int d, input bit e, input bit u,
                                     input bit l, input int g);
        int n, mx;
        bit sat;
        n   = (d == 2) ? 6 : 4;
        sat = (d == 1);
        mx  = (1 << n) - 1;
        if (l) begin
            mb[d]  = ref_g2b(g, n);
            mtc[d] = 0;
        end else if (e && u) begin
            if (mb[d] == mx) begin
                mtc[d] = 1;
                if (!sat) mb[d] = 0;
            end else begin
                mb[d]++;
                mtc[d] = 0;
            end
        end else if (e) begin
            if (mb[d] == 0) begin
                mtc[d] = 1;
                if (!sat) mb[d] = mx;
            end else begin
                mb[d]--;
                mtc[d] = 0;
            end
        end else begin
            mtc[d] = 0;
        end
    endfunction

    // Called at a falling edge: drive, predict, push; then check after the
    // next rising edge and return at the following falling edge.
    task automatic cyc(input int d, input bit e, input bit u, input bit l, input int g);
        exp_t x, y;
        int   ab, ag, at;
        en_v[d]   = e;
        up_v[d]   = u;
        load_v[d] = l;
        lg_v[d]   = 6'(g);
        ref_step(d, e, u, l, g);
        x.d = d;
        x.b = mb[d];
        x.g = mb[d] ^ (mb[d] >> 1);
        x.t = mtc[d];
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            y = sb.pop_front();
            get_act(y.d, ab, ag, at);
            chk("bin", ab, y.b);
            chk("gray", ag, y.g);
            chk("tc", at, y.t);
        end
        en_v[d]   = 1'b0;
        load_v[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag, input int d);
        int ab, ag, at;
        get_act(d, ab, ag, at);
        chk({tag, "_bin"}, ab, 0);
        chk({tag, "_gray"}, ag, 0);
        chk({tag, "_tc"}, at, 0);
    endtask

    int gseq [17];
    int ab, ag, at, pg;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 3; i++) begin
            en_v[i] = 1'b0; up_v[i] = 1'b0; load_v[i] = 1'b0; lg_v[i] = '0;
            mb[i] = 0; mtc[i] = 0;
        end
        gseq = '{'h0, 'h1, 'h3, 'h2, 'h6, 'h7, 'h5, 'h4, 'hC,
                 'hD, 'hF, 'hE, 'hA, 'hB, 'h9, 'h8, 'h0};

        rst = 1'b1;
        #12;
        for (int d = 0; d < 3; d++) chk_zero("rst_init", d);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-count at bin=5: load 4 (gray 6) then one up step.
        cyc(0, 1'b0, 1'b0, 1'b1, 'h6);
        cyc(0, 1'b1, 1'b1, 1'b0, 0);
        chk("pre_rst_bin", int'(bin0), 5);
        en_v[0] = 1'b1; up_v[0] = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_zero("rst_async", 0);
        @(posedge clk);
        #1;
        chk_zero("rst_held", 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin mb[i] = 0; mtc[i] = 0; end
        en_v[0] = 1'b0;
        for (int i = 0; i < 3; i++) cyc(0, 1'b0, 1'b1, 1'b0, 0);
        chk_zero("post_rst_hold", 0);

        // Down wrap from 0.
        cyc(0, 1'b1, 1'b0, 1'b0, 0);
        chk("dwrap_bin", int'(bin0), 15);
        chk("dwrap_gray", int'(gray0), 'b1000);
        chk("dwrap_tc", int'(tc0), 1);
        cyc(0, 1'b1, 1'b0, 1'b0, 0);
        chk("dwrap2_gray", int'(gray0), 'b1001);
        chk("dwrap2_tc", int'(tc0), 0);

        // Gray load with en high, then one up step.
        cyc(0, 1'b1, 1'b0, 1'b1, 'b1100);
        chk("load_bin", int'(bin0), 8);
        chk("load_tc", int'(tc0), 0);
        cyc(0, 1'b1, 1'b1, 1'b0, 0);
        chk("load_up_bin", int'(bin0), 9);
        chk("load_up_gray", int'(gray0), 'b1101);

        // Full up-count from 0, 17 steps.
        cyc(0, 1'b0, 1'b0, 1'b1, 0);
        pg = 0;
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 1'b1, 1'b1, 1'b0, 0);
            chk("upseq_gray", int'(gray0), gseq[i]);
            chk("upseq_1bit", $countones(4'(int'(gray0) ^ pg)), 1);
            chk("upseq_tc", int'(tc0), (i == 16) ? 1 : 0);
            pg = int'(gray0);
        end
        cyc(0, 1'b0, 1'b1, 1'b0, 0);
        chk("hold_gray", int'(gray0), pg);

        // Saturating instance.
        cyc(1, 1'b0, 1'b0, 1'b1, 'b1000);
        chk("sat_load_bin", int'(bin1), 15);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1'b1, 1'b1, 1'b0, 0);
            chk("sat_hold_bin", int'(bin1), 15);
            chk("sat_hold_tc", int'(tc1), 1);
        end
        cyc(1, 1'b1, 1'b0, 1'b0, 0);
        chk("sat_down_bin", int'(bin1), 14);
        chk("sat_down_tc", int'(tc1), 0);
        cyc(1, 1'b0, 1'b0, 1'b1, 0);
        cyc(1, 1'b1, 1'b0, 1'b0, 0);
        chk("sat_low_bin", int'(bin1), 0);
        chk("sat_low_tc", int'(tc1), 1);

        // Random run on the 6-bit instance.
        for (int i = 0; i < 1000; i++) begin
            cyc(2, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 7) == 0), int'($urandom_range(0, 63)));
        end

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
